// File: rtl/c432_obf_pkg.sv
// Shared definitions for the c432 key-delivery stage: state encoding,
// default parameters and the frame parity check.
package c432_obf_pkg;

    localparam int         KEY_W_DEF     = 2;
    localparam logic [1:0] RESET_KEY_DEF = 2'b10;
    localparam int         MAX_FAIL_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } key_state_e;

    // Even parity over a zero-extended frame: padding zeros leave the XOR
    // unchanged, so one helper serves any key width up to 31 bits.
    function automatic logic key_parity_ok(input logic [31:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Serial frame capture: KEY_W+1 bit shift register (new bits enter at the
// MSB, so after a full LSB-first frame bit i sits at index i) plus the
// bit counter. done fires on the edge that captures the final frame bit.
module obf_key_shreg
    import c432_obf_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic           sdi,
    output logic [KEY_W:0] frame,
    output logic           done
);

    localparam int               CNT_W    = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W);

    logic [KEY_W:0]   sr_reg, sr_next;
    logic [KEY_W:0]   sr_shift;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Right-shift chain feeding the serial input into the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_W; gi++) begin : g_shift
            assign sr_shift[gi] = sr_reg[gi+1];
        end
    endgenerate
    assign sr_shift[KEY_W] = sdi;

    // Clear wins over shifting, so a restart edge never counts its bit.
    always_comb begin
        sr_next  = sr_reg;
        cnt_next = cnt_reg;
        if (clr) begin
            sr_next  = '0;
            cnt_next = '0;
        end else if (en) begin
            sr_next  = sr_shift;
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            sr_reg  <= sr_next;
            cnt_reg <= cnt_next;
        end
    end

    assign frame = sr_reg;
    assign done  = en && !clr && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/c432_key_loader.sv
// Key-delivery stage for the locked c432 netlist. Captures a serial key
// frame, checks even parity, and only then exposes the key; otherwise the
// decoy RESET_KEY is driven. MAX_FAIL bad frames in a row lock out until reset.
module c432_key_loader
    import c432_obf_pkg::*;
#(
    parameter int               KEY_W     = KEY_W_DEF,
    parameter logic [KEY_W-1:0] RESET_KEY = RESET_KEY_DEF,
    parameter int               MAX_FAIL  = MAX_FAIL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_sen,
    input  logic             key_sdi,
    input  logic             key_clear,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             key_lockout,
    output logic             busy
);

    localparam int                FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

    key_state_e        state_reg, state_next;
    logic [KEY_W-1:0]  key_reg, key_next;
    logic [FAIL_W-1:0] fail_reg, fail_next;
    logic [FAIL_W-1:0] fail_inc;
    logic              fail_hit;

    logic              sh_clr;
    logic              sh_en;
    logic              sh_done;
    logic [KEY_W:0]    sh_frame;
    logic              parity_ok;

    // Capture is only live in SHIFT; any start or clear restarts it, and
    // outside SHIFT it is held cleared so every frame begins from zero.
    assign sh_en  = (state_reg == ST_SHIFT) && key_sen;
    assign sh_clr = (state_reg != ST_SHIFT) || key_start || key_clear;

    obf_key_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sh_clr),
        .en    (sh_en),
        .sdi   (key_sdi),
        .frame (sh_frame),
        .done  (sh_done)
    );

    assign parity_ok = key_parity_ok(32'(sh_frame));
    assign fail_inc  = (fail_reg == FAIL_MAX) ? fail_reg : fail_reg + FAIL_W'(1);
    assign fail_hit  = (fail_inc == FAIL_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; key_clear takes priority everywhere but LOCKOUT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (key_clear)      state_next = ST_IDLE;
                else if (key_start) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (key_clear)      state_next = ST_IDLE;
                else if (key_start) state_next = ST_SHIFT;
                else if (sh_done)   state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (key_clear)      state_next = ST_IDLE;
                else if (parity_ok) state_next = ST_LOCKED;
                else if (fail_hit)  state_next = ST_LOCKOUT;
                else                state_next = ST_ERROR;
            end
            ST_LOCKED: begin
                if (key_clear)      state_next = ST_IDLE;
            end
            ST_ERROR: begin
                if (key_clear)      state_next = ST_IDLE;
                else if (key_start) state_next = ST_SHIFT;
            end
            ST_LOCKOUT: begin
                state_next = ST_LOCKOUT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Key and fail-count updates: the key register only ever holds the
    // decoy or a fully checked frame, never partial shift data.
    always_comb begin
        key_next  = RESET_KEY;
        fail_next = fail_reg;
        if ((state_reg == ST_CHECK) && !key_clear) begin
            if (parity_ok) begin
                key_next  = sh_frame[KEY_W-1:0];
                fail_next = '0;
            end else begin
                fail_next = fail_inc;
            end
        end else if ((state_reg == ST_LOCKED) && !key_clear) begin
            key_next = key_reg;
        end
    end

    // Key output and fail counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg  <= RESET_KEY;
            fail_reg <= '0;
        end else begin
            key_reg  <= key_next;
            fail_reg <= fail_next;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        key_out     = key_reg;
        key_valid   = (state_reg == ST_LOCKED);
        key_err     = (state_reg == ST_ERROR);
        key_lockout = (state_reg == ST_LOCKOUT);
        busy        = (state_reg == ST_SHIFT) || (state_reg == ST_CHECK);
    end

endmodule
